fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Instruction-fetch stage feeding the IF/ID register of the 16-bit 5-stage pipeline.
- Issues word fetches to instruction memory with a req/gnt, rvalid handshake, and buffers returned instructions with their PC+2 in a small in-order queue.
- Presents the queue head to decode, which may stall it.
- Accepts a branch redirect from EX/MEM that flushes the queue and discards in-flight responses.

Parameters:
- DEPTH, 4: queue entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2: max accepted-but-unanswered memory requests (≤DEPTH).
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clock  in  1  pipeline clock; all state updates on falling edge, as in the rest of the pipeline
- reset  in  1  synchronous, active-high
- redirect  in  1  taken branch; load redirect_target
- redirect_target  in  16  byte address of branch target
- id_ready  in  1  decode accepts head entry this cycle
- imem_req  out  1  fetch request
- imem_addr  out  16  byte address; memory indexes word imem_addr>>1
- imem_gnt  in  1  request accepted when imem_req&&imem_gnt
- imem_rvalid  in  1  response valid; responses in request order
- imem_rdata  in  16  instruction word
- ifid_valid  out  1  queue non-empty
- ifid_ir  out  16  head instruction; 16'h0000 (nop) when empty
- ifid_pcplus2  out  16  head instruction address+2; 16'h0000 when empty

Behaviour:
- State:
  - fetch_pc: next address to request.
  - resp_pc: address of the next expected response.
  - queue: DEPTH entries of {ir, pcplus2}, with rd/wr pointers and count (0..DEPTH).
  - outstanding: 0..MAX_OUTSTANDING.
  - drop_cnt: 0..MAX_OUTSTANDING.
- Reset, synchronous and dominating all other inputs:
  - fetch_pc=resp_pc=RESET_PC.
  - count, outstanding, drop_cnt, pointers = 0.
  - imem_rvalid ignored.
  - Outputs: imem_req=0, ifid_valid=0, ifid_ir=0, ifid_pcplus2=0.
- Issue:
  - imem_req = !reset && !redirect && outstanding<MAX_OUTSTANDING && (count+outstanding-drop_cnt)<DEPTH.
  - imem_addr=fetch_pc.
  - On accept: fetch_pc += 2 (wraps mod 2^16), outstanding++.
- Response (imem_rvalid):
  - outstanding-- (a simultaneous accept nets to 0).
  - If drop_cnt>0: discard the word, drop_cnt--.
  - Else: push {imem_rdata, resp_pc+2}, then resp_pc += 2.
  - The credit rule guarantees no push when full. A push on a full queue is a fatal assertion.
- Pop: when ifid_valid && id_ready, advance rd pointer. Push and pop in the same cycle leave count unchanged.
- Output timing: head outputs are combinational from queue storage. Latency from accepted request to ifid_valid is one cycle after the imem_rvalid edge on an empty queue.
- Redirect (priority over pop, push and issue):
  - Queue emptied (count=0, pointers reset); any pop that cycle is ignored.
  - fetch_pc=resp_pc={redirect_target[15:1],1'b0}; bit0 is ignored.
  - A response arriving the same cycle is discarded.
  - drop_cnt = outstanding − (imem_rvalid?1:0) + (drop_cnt already pending is included in outstanding).
  - imem_req=0 in the redirect cycle. Issue resumes the next cycle.
- Back-to-back redirects: each one reloads the PCs and recomputes drop_cnt from the current outstanding.
- id_ready low: queue fills to DEPTH−outstanding, then imem_req drops. No entry is lost or duplicated.
- Reset mid-transaction: in-flight responses arriving after reset deasserts are treated as new data. The memory side must also be reset by the same reset.

Decomposition:
- Shared package:
  - NOP_INSTR=16'h0000.
  - PC_STEP=16'd2.
  - Typedef fq_entry_t {ir[15:0], pcplus2[15:0]}.
- Sub-module sync_fifo_flush: parameterised DEPTH×32 FIFO with push, pop, flush, count, full, empty. It holds the queue.
- The top level owns the PCs, credit counters and drop logic.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then memory with 1-cycle rvalid and gnt=1 returning word=addr>>1; id_ready=1.
  - Required: ifid_ir sequence 0,1,2,3…; ifid_pcplus2 sequence 2,4,6,8; no gaps after fill.
- Stall:
  - Stimulus: id_ready=0 for 10 cycles.
  - Required: count saturates at 4, imem_req=0, outstanding=0. On release, entries are delivered in order with none lost or duplicated.
- Redirect with in-flight responses:
  - Stimulus: 2 responses pending (latency 3), redirect to 16'h0020.
  - Required: both stale words discarded. Next ifid_ir=word 16 with ifid_pcplus2=16'h0022.
- Redirect coinciding with rvalid and a pop:
  - Required: queue empty next cycle, that response dropped, drop_cnt = outstanding−1.
- Odd target and wrap:
  - Redirect to 16'h0021 gives imem_addr=16'h0020.
  - Redirect to 16'hFFFE gives next requests FFFE then 0000, with ifid_pcplus2 0000 then 0002.
- Reset mid-stream:
  - Stimulus: assert reset with queue holding 3 entries.
  - Required: next cycle ifid_valid=0, ifid_ir=0, imem_req=0. First request after reset is to RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_queue_unit_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'd2;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pcplus2;
  } fq_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// In-order entry queue with single-cycle flush; head is read combinationally.
module sync_fifo_flush
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fq_entry_t        wdata,
  output fq_entry_t        rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  // Status flags and head read.
  always_comb begin
    full   = (count == CNT_W'(DEPTH));
    empty  = (count == '0);
    do_pop = pop && !empty;
    rdata  = mem[rd_ptr];
  end

  // Entry storage; flush or reset suppress the write.
  always_ff @(negedge clock) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(negedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: issues word fetches under a credit limit, queues responses
// with their PC+2, and flushes on branch redirect while dropping stale responses.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] RESET_PC        = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        ifid_valid,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pcplus2
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [15:0]      fetch_pc;
  logic [15:0]      resp_pc;
  logic [15:0]      target_pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_nxt;
  logic [OUT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  fq_entry_t        q_head;
  fq_entry_t        q_wdata;
  logic [31:0]      credit_used;
  logic             accept;
  logic             rsp_dec;
  logic             push;
  logic             pop;

  // Issue credit, handshake decode and queue control.
  always_comb begin
    credit_used = 32'(q_count) + 32'(outstanding) - 32'(drop_cnt);
    imem_req    = !reset && !redirect
                  && (32'(outstanding) < MAX_OUTSTANDING)
                  && (credit_used < DEPTH);
    imem_addr   = fetch_pc;
    accept      = imem_req && imem_gnt;
    // Responses with nothing outstanding (left over across reset) still count as data.
    rsp_dec     = imem_rvalid && (outstanding != '0);
    outstanding_nxt = outstanding;
    if (accept && !rsp_dec) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!accept && rsp_dec) begin
      outstanding_nxt = outstanding - 1'b1;
    end
    push      = imem_rvalid && (drop_cnt == '0) && !redirect && !reset;
    pop       = !q_empty && id_ready && !redirect && !reset;
    q_wdata   = '{ir: imem_rdata, pcplus2: resp_pc + PC_STEP};
    target_pc = redirect_target & 16'hFFFE;
  end

  // Head presentation; nop and zero PC when nothing is queued.
  always_comb begin
    ifid_valid   = !q_empty;
    ifid_ir      = q_empty ? NOP_INSTR : q_head.ir;
    ifid_pcplus2 = q_empty ? 16'h0000  : q_head.pcplus2;
  end

  // PC, credit and drop-count state.
  always_ff @(negedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Everything still in flight after this edge is stale.
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (imem_rvalid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
          end else begin
            resp_pc <= resp_pc + PC_STEP;
          end
        end
      end
    end
  end

  // The credit rule must never let a response land on a full queue.
  always_ff @(negedge clock) begin
    assert (!(push && q_full)) else $fatal(1, "fetch queue overflow");
  end

  sync_fifo_flush #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit with a queue-based reference model.
module tb_fetch_queue_unit;
  import fetch_queue_unit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        id_ready;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_ir;
  logic [15:0] ifid_pcplus2;

  fetch_queue_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .ifid_valid      (ifid_valid),
    .ifid_ir         (ifid_ir),
    .ifid_pcplus2    (ifid_pcplus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: accepted requests waiting for their response cycle.
  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];

  // Model: requests in flight (stale once overtaken by a redirect) and queued entries.
  typedef struct {
    logic [15:0] addr;
    bit          stale;
  } infl_t;
  infl_t       infl[$];
  fq_entry_t   mq[$];
  logic [15:0] m_fetch;

  int errors;
  int checks;
  int cyc;
  bit found;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_req(input bit rst, input bit redir);
    int live;
    live = 0;
    foreach (infl[i]) if (!infl[i].stale) live++;
    return !rst && !redir && (infl.size() < MAXO) && ((mq.size() + live) < DEPTH);
  endfunction

  // One clock: drive inputs, check outputs, then advance memory and model past the edge.
  task automatic step(input bit rst, input bit redir, input logic [15:0] tgt,
                      input bit rdy, input bit gnt, input int lat);
    bit        rv;
    bit        exp_req;
    infl_t     f;
    fq_entry_t e;
    @(posedge clock);
    reset           = rst;
    redirect        = redir;
    redirect_target = tgt;
    id_ready        = rdy;
    imem_gnt        = gnt;
    rv              = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid     = rv;
    if (rv) imem_rdata = mem_q[0].addr >> 1;
    else    imem_rdata = 16'($urandom);
    #1;
    exp_req = model_req(rst, redir);
    check_eq("imem_req", 16'(imem_req), 16'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, m_fetch);
    check_eq("ifid_valid", 16'(ifid_valid), 16'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_eq("ifid_ir", ifid_ir, mq[0].ir);
      check_eq("ifid_pcplus2", ifid_pcplus2, mq[0].pcplus2);
    end else begin
      check_eq("ifid_ir_empty", ifid_ir, NOP_INSTR);
      check_eq("ifid_pcplus2_empty", ifid_pcplus2, 16'h0000);
    end
    if (rst) begin
      mem_q.delete();
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) mem_q.push_back('{addr: imem_addr, due: cyc + lat});
    end
    if (rst) begin
      m_fetch = RPC;
      mq.delete();
      infl.delete();
    end else begin
      if (!redir && rdy && mq.size() > 0) void'(mq.pop_front());
      if (rv && infl.size() > 0) begin
        f = infl.pop_front();
        if (!f.stale && !redir) begin
          e.ir      = f.addr >> 1;
          e.pcplus2 = f.addr + PC_STEP;
          mq.push_back(e);
        end
      end
      if (redir) begin
        mq.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        m_fetch = {tgt[15:1], 1'b0};
      end else if (exp_req && gnt) begin
        infl.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + PC_STEP;
      end
    end
    cyc++;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    cyc             = 0;
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_target = 16'h0000;
    id_ready        = 1'b0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 16'h0000;
    m_fetch         = RPC;
    repeat (2) @(negedge clock);

    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1);

    // Sequential fetch, single-cycle memory.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1);

    // Decode stall then release.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
    check_eq("stall_req", 16'(imem_req), 16'd0);
    check_eq("stall_valid", 16'(ifid_valid), 16'd1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1);

    // Redirect with two responses in flight.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (infl.size() == 2) found = 1'b1;
      else step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 3);
    end
    check_eq("wait_inflight", 16'(found), 16'd1);
    step(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 3);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() > 0) found = 1'b1;
      else step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3);
    end
    check_eq("wait_refill", 16'(found), 16'd1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);
    check_eq("redir_ir", ifid_ir, 16'd16);
    check_eq("redir_pcplus2", ifid_pcplus2, 16'h0022);

    // Redirect coinciding with a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && mq.size() > 0) begin
        step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 2);
        found = 1'b1;
      end else begin
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 2);
      end
    end
    check_eq("wait_coincide", 16'(found), 16'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
    check_eq("coincide_empty", 16'(ifid_valid), 16'd0);

    // Odd redirect target.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 16'h0021, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
    check_eq("odd_req", 16'(imem_req), 16'd1);
    check_eq("odd_addr", imem_addr, 16'h0020);

    // Address wrap.
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
    check_eq("wrap_ir0", ifid_ir, 16'h7FFF);
    check_eq("wrap_pc0", ifid_pcplus2, 16'h0000);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);
    check_eq("wrap_ir1", ifid_ir, 16'h0000);
    check_eq("wrap_pc1", ifid_pcplus2, 16'h0002);

    // Reset with three entries queued.
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 3) found = 1'b1;
      else step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
    end
    check_eq("wait_three", 16'(found), 16'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1);
    check_eq("rst_valid", 16'(ifid_valid), 16'd0);
    check_eq("rst_ir", ifid_ir, 16'h0000);
    check_eq("rst_req", 16'(imem_req), 16'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
    check_eq("post_rst_req", 16'(imem_req), 16'd1);
    check_eq("post_rst_addr", imem_addr, RPC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(19) == 0, 16'($urandom),
           $urandom_range(9) < 7, $urandom_range(9) < 7, int'($urandom_range(3, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
